// File: rtl/alu_reservation_station.sv
// Reservation station with a single-cycle integer ALU and a registered, ROB-tagged result broadcast.
// Optional build macro RS_WAKEUP_BYPASS_EN lets select use operands satisfied by this cycle's broadcasts.
`ifndef ROB_BIT
`define ROB_BIT 4
`endif
`ifndef R_TYPE
`define R_TYPE 7'b0110011
`endif
`ifndef I_TYPE
`define I_TYPE 7'b0010011
`endif
`ifndef B_TYPE
`define B_TYPE 7'b1100011
`endif

module alu_reservation_station #(
    parameter int RS_BIT = 3
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                rdy_in,
    input  logic                clear_up,
    output logic                rs_full,
    input  logic                issue_signal,
    input  logic [6:0]          op_type_in,
    input  logic [2:0]          op_in,
    input  logic                op_alt_in,
    input  logic [`ROB_BIT-1:0] rob_entry_in,
    input  logic [31:0]         vj_in,
    input  logic [31:0]         vk_in,
    input  logic                qj_rdy_in,
    input  logic                qk_rdy_in,
    input  logic [`ROB_BIT-1:0] qj_in,
    input  logic [`ROB_BIT-1:0] qk_in,
    input  logic                lsb_ready_bd,
    input  logic [`ROB_BIT-1:0] lsb_rob_entry,
    input  logic [31:0]         lsb_value,
    output logic                rs_ready_bd,
    output logic [`ROB_BIT-1:0] rs_rob_entry,
    output logic [31:0]         rs_value
);
    localparam int RS_SIZE = 1 << RS_BIT;
    localparam int RB      = `ROB_BIT;

    logic [RS_SIZE-1:0] busy_reg;
    logic [6:0]         op_type_reg [RS_SIZE];
    logic [2:0]         op_reg      [RS_SIZE];
    logic               alt_reg     [RS_SIZE];
    logic [RB-1:0]      rob_reg     [RS_SIZE];
    logic [31:0]        vj_reg      [RS_SIZE];
    logic [31:0]        vk_reg      [RS_SIZE];
    logic               qj_rdy_reg  [RS_SIZE];
    logic               qk_rdy_reg  [RS_SIZE];
    logic [RB-1:0]      qj_reg      [RS_SIZE];
    logic [RB-1:0]      qk_reg      [RS_SIZE];

    logic [RS_SIZE-1:0] j_wake, k_wake, j_ok, k_ok, cand;
    logic [31:0]        j_wake_val [RS_SIZE];
    logic [31:0]        k_wake_val [RS_SIZE];
    logic [31:0]        j_fwd      [RS_SIZE];
    logic [31:0]        k_fwd      [RS_SIZE];

    logic               sel_valid;
    logic [RS_BIT-1:0]  sel_idx;
    logic [RS_BIT-1:0]  free_idx;
    logic               issue_ok;
    logic [31:0]        alu_result;

    function automatic logic [31:0] alu(input logic [6:0] op_type, input logic [2:0] op,
                                        input logic alt, input logic [31:0] a, input logic [31:0] b);
        logic taken;
        logic [31:0] res;
        taken = 1'b0;
        res   = '0;
        if (op_type == `B_TYPE) begin
            case (op)
                3'b000:  taken = (a == b);
                3'b001:  taken = (a != b);
                3'b100:  taken = ($signed(a) < $signed(b));
                3'b101:  taken = ($signed(a) >= $signed(b));
                3'b110:  taken = (a < b);
                3'b111:  taken = (a >= b);
                default: taken = 1'b0;
            endcase
            res = {31'b0, taken};
        end else begin
            case (op)
                // alt selects SUB only for register ops; immediates carry imm bits there
                3'b000:  res = (op_type == `R_TYPE && alt) ? a - b : a + b;
                3'b001:  res = a << b[4:0];
                3'b010:  res = {31'b0, ($signed(a) < $signed(b))};
                3'b011:  res = {31'b0, (a < b)};
                3'b100:  res = a ^ b;
                3'b101:  res = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                3'b110:  res = a | b;
                default: res = a & b;
            endcase
        end
        return res;
    endfunction

    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
        logic j_rs_hit, j_lsb_hit, k_rs_hit, k_lsb_hit;
        assign j_rs_hit  = rs_ready_bd  && (rs_rob_entry  == qj_reg[gi]);
        assign j_lsb_hit = lsb_ready_bd && (lsb_rob_entry == qj_reg[gi]);
        assign k_rs_hit  = rs_ready_bd  && (rs_rob_entry  == qk_reg[gi]);
        assign k_lsb_hit = lsb_ready_bd && (lsb_rob_entry == qk_reg[gi]);
        assign j_wake[gi] = !qj_rdy_reg[gi] && (j_rs_hit || j_lsb_hit);
        assign k_wake[gi] = !qk_rdy_reg[gi] && (k_rs_hit || k_lsb_hit);
        assign j_wake_val[gi] = j_rs_hit ? rs_value : lsb_value;
        assign k_wake_val[gi] = k_rs_hit ? rs_value : lsb_value;
`ifdef RS_WAKEUP_BYPASS_EN
        assign j_ok[gi]  = qj_rdy_reg[gi] || j_wake[gi];
        assign k_ok[gi]  = qk_rdy_reg[gi] || k_wake[gi];
        assign j_fwd[gi] = qj_rdy_reg[gi] ? vj_reg[gi] : j_wake_val[gi];
        assign k_fwd[gi] = qk_rdy_reg[gi] ? vk_reg[gi] : k_wake_val[gi];
`else
        assign j_ok[gi]  = qj_rdy_reg[gi];
        assign k_ok[gi]  = qk_rdy_reg[gi];
        assign j_fwd[gi] = vj_reg[gi];
        assign k_fwd[gi] = vk_reg[gi];
`endif
        assign cand[gi] = busy_reg[gi] && j_ok[gi] && k_ok[gi];
    end

    // Downward scans leave the lowest matching index in the result.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_valid = 1'b1;
                sel_idx   = RS_BIT'(i);
            end
            if (!busy_reg[i]) begin
                free_idx = RS_BIT'(i);
            end
        end
    end

    assign rs_full    = &busy_reg;
    assign issue_ok   = issue_signal && !rs_full;
    assign alu_result = alu(op_type_reg[sel_idx], op_reg[sel_idx], alt_reg[sel_idx],
                            j_fwd[sel_idx], k_fwd[sel_idx]);

    logic          iss_j_rs, iss_j_lsb, iss_k_rs, iss_k_lsb;
    logic [31:0]   iss_vj, iss_vk;
    assign iss_j_rs  = rs_ready_bd  && (rs_rob_entry  == qj_in);
    assign iss_j_lsb = lsb_ready_bd && (lsb_rob_entry == qj_in);
    assign iss_k_rs  = rs_ready_bd  && (rs_rob_entry  == qk_in);
    assign iss_k_lsb = lsb_ready_bd && (lsb_rob_entry == qk_in);
    assign iss_vj = qj_rdy_in ? vj_in : iss_j_rs ? rs_value : iss_j_lsb ? lsb_value : vj_in;
    assign iss_vk = qk_rdy_in ? vk_in : iss_k_rs ? rs_value : iss_k_lsb ? lsb_value : vk_in;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            busy_reg     <= '0;
            rs_ready_bd  <= 1'b0;
            rs_rob_entry <= '0;
            rs_value     <= '0;
        end else if (rdy_in) begin
            if (clear_up) begin
                busy_reg    <= '0;
                rs_ready_bd <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (j_wake[i]) begin
                        qj_rdy_reg[i] <= 1'b1;
                        vj_reg[i]     <= j_wake_val[i];
                    end
                    if (k_wake[i]) begin
                        qk_rdy_reg[i] <= 1'b1;
                        vk_reg[i]     <= k_wake_val[i];
                    end
                end
                if (sel_valid) begin
                    busy_reg[sel_idx] <= 1'b0;
                end
                // Issue targets a slot that was free before this edge, so it never collides with select.
                if (issue_ok) begin
                    busy_reg[free_idx]    <= 1'b1;
                    op_type_reg[free_idx] <= op_type_in;
                    op_reg[free_idx]      <= op_in;
                    alt_reg[free_idx]     <= op_alt_in;
                    rob_reg[free_idx]     <= rob_entry_in;
                    vj_reg[free_idx]      <= iss_vj;
                    vk_reg[free_idx]      <= iss_vk;
                    qj_rdy_reg[free_idx]  <= qj_rdy_in || iss_j_rs || iss_j_lsb;
                    qk_rdy_reg[free_idx]  <= qk_rdy_in || iss_k_rs || iss_k_lsb;
                    qj_reg[free_idx]      <= qj_in;
                    qk_reg[free_idx]      <= qk_in;
                end
                rs_ready_bd <= sel_valid;
                if (sel_valid) begin
                    rs_rob_entry <= rob_reg[sel_idx];
                    rs_value     <= alu_result;
                end
            end
        end
    end

endmodule
